// File: rtl/gmsk_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gmsk_pkg: burst framing states and shared framing constants        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package gmsk_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LEAD  = 3'd1,
      DATA  = 3'd2,
      TAIL  = 3'd3,
      GUARD = 3'd4
   } gmsk_state_e;

   localparam int TAIL_BITS_DEFAULT     = 3;
   localparam int GUARD_SYMBOLS_DEFAULT = 8;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/gmsk_strobe_divider.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gmsk_strobe_divider: free-running divider, one-cycle sample strobe |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module gmsk_strobe_divider #(
   parameter int CLK_DIV = 4
) (
   input  logic clock,
   input  logic reset_n,
   output logic sample_strobe
);

   localparam int            CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             strobe_q, strobe_d;

   // Strobe is registered against the next count so it is high while cnt_q == LAST.
   always_comb begin
      cnt_d    = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      strobe_d = (cnt_d == LAST);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q    <= '0;
         strobe_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         strobe_q <= strobe_d;
      end
   end

   assign sample_strobe = strobe_q;

endmodule
`default_nettype wire

// File: rtl/gmsk_burst_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gmsk_burst_sequencer: frames lead/payload/tail/guard symbols       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module gmsk_burst_sequencer
   import gmsk_pkg::*;
#(
   parameter int CLK_DIV       = 4,
   parameter int LEN_BITS      = 8,
   parameter int TAIL_BITS     = TAIL_BITS_DEFAULT,
   parameter int GUARD_SYMBOLS = GUARD_SYMBOLS_DEFAULT
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                start,
   input  logic [LEN_BITS-1:0] payload_length,
   input  logic                bit_data,
   input  logic                bit_valid,
   output logic                bit_ready,
   input  logic                next_symbol_strobe,
   output logic                sample_strobe,
   output logic                current_symbol,
   output logic                tx_active,
   output logic                busy,
   output logic                burst_done,
   output logic                underrun
);

   localparam int CNT_W = max3(LEN_BITS, $clog2(GUARD_SYMBOLS + 1), $clog2(TAIL_BITS + 1));
   localparam logic [CNT_W-1:0] TAIL_LAST  = CNT_W'(TAIL_BITS);
   localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_SYMBOLS);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   gmsk_state_e         state_q, state_d;
   logic [CNT_W-1:0]    sym_cnt_q, sym_cnt_d;
   logic [LEN_BITS-1:0] len_q, len_d;
   logic                nss_q, nss_d;
   logic                start_pending_q, start_pending_d;
   logic                cur_sym_q, cur_sym_d;
   logic                tx_active_q, tx_active_d;
   logic                burst_done_q, burst_done_d;
   logic                underrun_q, underrun_d;
   logic                advance, consume, start_accept;
   logic [CNT_W-1:0]    len_ext;

   gmsk_strobe_divider #(.CLK_DIV(CLK_DIV)) u_divider (
      .clock         (clock),
      .reset_n       (reset_n),
      .sample_strobe (sample_strobe)
   );

   assign len_ext = CNT_W'(len_q);

   always_comb begin
      advance         = next_symbol_strobe & ~nss_q;
      nss_d           = next_symbol_strobe;
      start_accept    = start & (state_q == IDLE) & ~start_pending_q & (payload_length != '0);
      state_d         = state_q;
      sym_cnt_d       = sym_cnt_q;
      len_d           = len_q;
      start_pending_d = start_pending_q;
      cur_sym_d       = cur_sym_q;
      underrun_d      = underrun_q;
      burst_done_d    = 1'b0;
      consume         = 1'b0;

      if (start_accept) begin
         len_d           = payload_length;
         start_pending_d = 1'b1;
         underrun_d      = 1'b0;
      end

      if (advance) begin
         case (state_q)
            IDLE: begin
               cur_sym_d = 1'b0;
               if (start_pending_q) begin
                  state_d         = LEAD;
                  start_pending_d = 1'b0;
                  sym_cnt_d       = CNT_ONE;
               end
            end
            LEAD: begin
               if (sym_cnt_q == TAIL_LAST) begin
                  state_d   = DATA;
                  sym_cnt_d = CNT_ONE;
                  consume   = 1'b1;
               end else begin
                  sym_cnt_d = sym_cnt_q + 1'b1;
                  cur_sym_d = 1'b0;
               end
            end
            DATA: begin
               if (sym_cnt_q == len_ext) begin
                  state_d   = TAIL;
                  sym_cnt_d = CNT_ONE;
                  cur_sym_d = 1'b0;
               end else begin
                  sym_cnt_d = sym_cnt_q + 1'b1;
                  consume   = 1'b1;
               end
            end
            TAIL: begin
               cur_sym_d = 1'b0;
               if (sym_cnt_q == TAIL_LAST) begin
                  state_d   = GUARD;
                  sym_cnt_d = CNT_ONE;
               end else begin
                  sym_cnt_d = sym_cnt_q + 1'b1;
               end
            end
            GUARD: begin
               cur_sym_d = 1'b0;
               if (sym_cnt_q == GUARD_LAST) begin
                  state_d      = IDLE;
                  sym_cnt_d    = '0;
                  burst_done_d = 1'b1;
               end else begin
                  sym_cnt_d = sym_cnt_q + 1'b1;
               end
            end
            default: begin
               state_d   = IDLE;
               sym_cnt_d = '0;
               cur_sym_d = 1'b0;
            end
         endcase
      end

      // A missing bit still occupies its slot so the burst length never stretches.
      if (consume) begin
         cur_sym_d = bit_valid ? bit_data : 1'b0;
         if (!bit_valid) underrun_d = 1'b1;
      end

      tx_active_d = (state_d == LEAD) | (state_d == DATA) | (state_d == TAIL);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= IDLE;
         sym_cnt_q       <= '0;
         len_q           <= '0;
         nss_q           <= 1'b0;
         start_pending_q <= 1'b0;
         cur_sym_q       <= 1'b0;
         tx_active_q     <= 1'b0;
         burst_done_q    <= 1'b0;
         underrun_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         sym_cnt_q       <= sym_cnt_d;
         len_q           <= len_d;
         nss_q           <= nss_d;
         start_pending_q <= start_pending_d;
         cur_sym_q       <= cur_sym_d;
         tx_active_q     <= tx_active_d;
         burst_done_q    <= burst_done_d;
         underrun_q      <= underrun_d;
      end
   end

   assign bit_ready      = consume;
   assign current_symbol = cur_sym_q;
   assign tx_active      = tx_active_q;
   assign busy           = (state_q != IDLE) | start_pending_q;
   assign burst_done     = burst_done_q;
   assign underrun       = underrun_q;

endmodule
`default_nettype wire
